// File: rtl/alu_result_skid.sv
// Registered ALU result stage: flag derivation, two-entry skid buffer and overflow tracking.
// in_ready depends only on registered occupancy, so out_ready never reaches the ALU combinationally.
module alu_result_skid #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_v,
  input  logic             in_cout,
  input  logic [2:0]       in_sel,
  input  logic [TAGW-1:0]  in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_z,
  output logic             out_n,
  output logic             out_c,
  output logic             out_v,
  output logic             ovf_sticky,
  input  logic             ovf_clear,
  output logic [CNTW-1:0]  ovf_count
);

  // Entry layout: {d, tag, z, n, c, v}
  localparam int EW = WIDTH + TAGW + 4;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          state_reg, state_next;
  logic [EW-1:0]   head_reg, head_next;
  logic [EW-1:0]   skid_reg, skid_next;
  logic [EW-1:0]   new_entry;
  logic            ovf_sticky_reg, ovf_sticky_next;
  logic [CNTW-1:0] ovf_count_reg, ovf_count_next;
  logic            accept, pop, arith, new_v;

  // Carry and overflow are only meaningful for add/sub selects.
  assign arith     = (in_sel == 3'b010) || (in_sel == 3'b011);
  assign new_v     = arith & in_v;
  assign new_entry = {in_d, in_tag, (in_d == '0), in_d[WIDTH-1], arith & in_cout, new_v};

  assign in_ready  = (state_reg != TWO);
  assign out_valid = (state_reg != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign {out_d, out_tag, out_z, out_n, out_c, out_v} = head_reg;
  assign ovf_sticky = ovf_sticky_reg;
  assign ovf_count  = ovf_count_reg;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            head_next  = new_entry;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state_next = TWO;
            skid_next  = new_entry;
          end else if (accept && pop) begin
            head_next  = new_entry;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_next = ONE;
            head_next  = skid_reg;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // An overflowing accept beats a coincident clear; the count then restarts at one.
  always_comb begin
    ovf_sticky_next = ovf_sticky_reg;
    ovf_count_next  = ovf_count_reg;
    if (accept && new_v) begin
      ovf_sticky_next = 1'b1;
      if (ovf_clear)
        ovf_count_next = CNTW'(1);
      else if (ovf_count_reg != '1)
        ovf_count_next = ovf_count_reg + CNTW'(1);
    end else if (ovf_clear) begin
      ovf_sticky_next = 1'b0;
      ovf_count_next  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= EMPTY;
      head_reg       <= '0;
      skid_reg       <= '0;
      ovf_sticky_reg <= 1'b0;
      ovf_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      head_reg       <= head_next;
      skid_reg       <= skid_next;
      ovf_sticky_reg <= ovf_sticky_next;
      ovf_count_reg  <= ovf_count_next;
    end
  end

endmodule

// File: tb/tb_alu_result_skid.sv
// Directed bench for alu_result_skid: flags, back-pressure, streaming, overflow, flush and reset.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
module tb_alu_result_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_d;
  logic        in_v;
  logic        in_cout;
  logic [2:0]  in_sel;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_d;
  logic [4:0]  out_tag;
  logic        out_z, out_n, out_c, out_v;
  logic        ovf_sticky;
  logic        ovf_clear;
  logic [7:0]  ovf_count;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  alu_result_skid #(.WIDTH(32), .TAGW(5), .CNTW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d), .in_v(in_v),
    .in_cout(in_cout), .in_sel(in_sel), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_tag(out_tag),
    .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_v(out_v),
    .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear), .ovf_count(ovf_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] sel,
                       input logic co, input logic ov, input logic [4:0] tg);
    in_valid = v; in_d = d; in_sel = sel; in_cout = co; in_v = ov; in_tag = tg;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; ovf_clear = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0);
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_d", out_d, 32'd0);
    check("rst_flags", {28'd0, out_z, out_n, out_c, out_v}, 32'd0);
    check("rst_ovf", {23'd0, ovf_sticky, ovf_count}, 32'd0);
    rst = 1'b0;

    // Zero result from add: z=1, c=cout
    drive(1'b1, 32'h0, 3'b010, 1'b1, 1'b0, 5'd3);
    tick();
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_flags_zncv", {28'd0, out_z, out_n, out_c, out_v}, 32'b1010);
    check("t1_tag", 32'(out_tag), 32'd3);
    drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0);
    out_ready = 1'b1;
    tick();
    check("t1_drained", 32'(out_valid), 32'd0);

    // Logic op: carry/overflow masked, sticky untouched
    drive(1'b1, 32'h8000_0000, 3'b100, 1'b1, 1'b1, 5'd7);
    tick();
    check("t2_flags_zncv", {28'd0, out_z, out_n, out_c, out_v}, 32'b0100);
    check("t2_sticky", 32'(ovf_sticky), 32'd0);
    drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0);
    tick();

    // Back-pressure: A, B absorbed, C held off
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 3'b000, 1'b0, 1'b0, 5'd1);
    tick();
    check("bp_a_head", out_d, 32'hA);
    check("bp_a_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'hB, 3'b000, 1'b0, 1'b0, 5'd2);
    tick();
    check("bp_b_ready", 32'(in_ready), 32'd0);
    check("bp_b_head", out_d, 32'hA);
    drive(1'b1, 32'hC, 3'b000, 1'b0, 1'b0, 5'd3);
    tick();
    check("bp_c_blocked", 32'(in_ready), 32'd0);
    check("bp_c_head", out_d, 32'hA);
    out_ready = 1'b1;
    tick();
    check("bp_pop1_head", out_d, 32'hB);
    check("bp_pop1_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_pop2_head", out_d, 32'hC);
    check("bp_pop2_valid", 32'(out_valid), 32'd1);
    check("bp_pop2_tag", 32'(out_tag), 32'd3);
    drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Streaming with accept and pop in the same cycle
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(100 + i), 3'b000, 1'b0, 1'b0, 5'(i));
      tick();
      check($sformatf("stream%0d_d", i), out_d, 32'(100 + i));
      check($sformatf("stream%0d_ready", i), 32'(in_ready), 32'd1);
    end
    drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0);
    tick();
    check("stream_empty", 32'(out_valid), 32'd0);

    // Overflow counter saturation
    drive(1'b1, 32'h1, 3'b011, 1'b0, 1'b1, 5'd4);
    tick();
    check("ovf_first_count", 32'(ovf_count), 32'd1);
    for (int i = 1; i < 300; i++) tick();
    check("ovf_sat_sticky", 32'(ovf_sticky), 32'd1);
    check("ovf_sat_count", 32'(ovf_count), 32'd255);
    ovf_clear = 1'b1;
    tick();
    check("ovf_clr_set_sticky", 32'(ovf_sticky), 32'd1);
    check("ovf_clr_set_count", 32'(ovf_count), 32'd1);
    drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0);
    tick();
    check("ovf_clr_sticky", 32'(ovf_sticky), 32'd0);
    check("ovf_clr_count", 32'(ovf_count), 32'd0);
    ovf_clear = 1'b0;

    // Flush in TWO
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 3'b011, 1'b0, 1'b1, 5'd5);
    tick();
    drive(1'b1, 32'h22, 3'b011, 1'b0, 1'b1, 5'd6);
    tick();
    check("fl_two_ready", 32'(in_ready), 32'd0);
    check("fl_two_count", 32'(ovf_count), 32'd2);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h33, 3'b011, 1'b0, 1'b1, 5'd7);
    tick();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    check("fl_sticky", 32'(ovf_sticky), 32'd1);
    check("fl_count", 32'(ovf_count), 32'd2);
    flush = 1'b0;

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0000, 3'b011, 1'b1, 1'b1, 5'd9);
    tick();
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    check("ar_pre_flags", {28'd0, out_z, out_n, out_c, out_v}, 32'b0111);
    drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_ready", 32'(in_ready), 32'd1);
    check("ar_d", out_d, 32'd0);
    check("ar_tag_flags", {23'd0, out_tag, out_z, out_n, out_c, out_v}, 32'd0);
    check("ar_ovf", {23'd0, ovf_sticky, ovf_count}, 32'd0);
    tick();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
